// File: rtl/fht_pkg.sv
// Shared constants for the FHT datapath: coefficient encodings and rounding mode.
package fht_pkg;

  localparam int unsigned FHT_FRAC           = 8;
  localparam int unsigned FHT_COEF_SQRT2     = 362;
  localparam int unsigned FHT_COEF_INV_SQRT2 = 181;

  typedef enum logic {
    RoundTrunc    = 1'b0,
    RoundHalfAway = 1'b1
  } round_mode_e;

endpackage

// File: rtl/fht_scale_round.sv
// Final multiplier stage: drop FRAC fractional bits of |a|*COEF, optionally round, restore sign.
module fht_scale_round
  import fht_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned FRAC  = FHT_FRAC,
  parameter int unsigned ROUND = 0
) (
  input  logic            sign_i,
  input  logic [N+FRAC:0] prod_i,
  output logic [N:0]      p_o
);

  localparam round_mode_e Mode = (ROUND != 0) ? RoundHalfAway : RoundTrunc;
  // Rounding on the magnitude gives round-half-away-from-zero once the sign is restored.
  localparam logic [N+FRAC:0] Half =
      (Mode == RoundHalfAway) ? ((N+FRAC+1)'(1) << (FRAC - 1)) : '0;

  logic [N+FRAC:0] biased;
  logic [N:0]      q;

  always_comb begin
    biased = prod_i + Half;
    q      = (N+1)'(biased >> FRAC);
    p_o    = sign_i ? -q : q;
  end

endmodule

// File: rtl/fht_const_mult_pipe.sv
// Three-stage signed multiply by a selectable FHT constant with valid/ready flow control.
module fht_const_mult_pipe
  import fht_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned FRAC   = FHT_FRAC,
  parameter int unsigned COEF_A = FHT_COEF_SQRT2,
  parameter int unsigned COEF_B = FHT_COEF_INV_SQRT2,
  parameter int unsigned ROUND  = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic         in_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_p
);

  localparam int unsigned PW = N + FRAC + 1;
  localparam logic [PW-1:0] CoefA = PW'(COEF_A);
  localparam logic [PW-1:0] CoefB = PW'(COEF_B);

  logic          en;
  logic          s1_valid_q, s1_sign_q, s1_sel_q;
  logic [N-1:0]  s1_mag_q, s1_mag_d;
  logic          s2_valid_q, s2_sign_q;
  logic [PW-1:0] s2_prod_q, s2_prod_d;
  logic          out_valid_q;
  logic [N:0]    out_p_q, out_p_d;

  // Whole pipe advances in lockstep; bubbles are kept, so latency is fixed.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  always_comb begin
    // N-bit unsigned magnitude holds 2^(N-1) for the most negative input.
    s1_mag_d  = in_a[N-1] ? -in_a : in_a;
    s2_prod_d = PW'(s1_mag_q) * (s1_sel_q ? CoefB : CoefA);
  end

  fht_scale_round #(
    .N     (N),
    .FRAC  (FRAC),
    .ROUND (ROUND)
  ) u_scale_round (
    .sign_i (s2_sign_q),
    .prod_i (s2_prod_q),
    .p_o    (out_p_d)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sel_q    <= 1'b0;
      s1_mag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
    end else if (en) begin
      s1_valid_q  <= in_valid;
      s1_sign_q   <= in_a[N-1];
      s1_sel_q    <= in_sel;
      s1_mag_q    <= s1_mag_d;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_prod_q   <= s2_prod_d;
      out_valid_q <= s2_valid_q;
      // A bubble leaves the last result on out_p.
      if (s2_valid_q) begin
        out_p_q <= out_p_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

endmodule

// File: tb/tb_fht_const_mult_pipe.sv
// Directed bench: one truncating and one rounding instance driven from the same stimulus.
module tb_fht_const_mult_pipe;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sel = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_a = '0;
  logic       in_ready0, in_ready1, out_valid0, out_valid1;
  logic [8:0] out_p0, out_p1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fht_const_mult_pipe #(.N(8), .FRAC(8), .COEF_A(362), .COEF_B(181), .ROUND(0)) dut0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a),
    .in_sel(in_sel), .out_valid(out_valid0), .out_ready(out_ready), .out_p(out_p0)
  );

  fht_const_mult_pipe #(.N(8), .FRAC(8), .COEF_A(362), .COEF_B(181), .ROUND(1)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a),
    .in_sel(in_sel), .out_valid(out_valid1), .out_ready(out_ready), .out_p(out_p1)
  );

  // Hand-computed: sel=0 -> 362/256, sel=1 -> 181/256; e0 truncates, e1 rounds half away.
  int ar_a[7]  = '{-128, 127, 0, 64, -64, 100, 0};
  int ar_s[7]  = '{0, 0, 0, 0, 0, 1, 1};
  int ar_e0[7] = '{-181, 179, 0, 90, -90, 70, 0};
  int ar_e1[7] = '{-181, 180, 0, 91, -91, 71, 0};

  int st_a[10]  = '{10, 20, -30, 40, 50, -60, 70, -80, 90, -1};
  int st_e0[10] = '{14, 14, -42, 28, 70, -42, 98, -56, 127, 0};
  int st_e1[10] = '{14, 14, -42, 28, 71, -42, 99, -57, 127, -1};

  int sl_a[3]  = '{100, -128, 127};
  int sl_s[3]  = '{0, 1, 1};
  int sl_e0[3] = '{141, -90, 89};
  int sl_e1[3] = '{141, -91, 90};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input logic s);
    in_valid = v;
    in_a     = 8'(a);
    in_sel   = s;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      $display("FAIL reset_valid: got %b/%b want 0/0", out_valid0, out_valid1);
    end else n_pass++;
    n_total++;
    if (out_p0 !== 9'd0 || out_p1 !== 9'd0) begin
      $display("FAIL reset_p: got %h/%h want 000/000", out_p0, out_p1);
    end else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    n_total++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready0,
               out_valid0);
    end else n_pass++;
  endtask

  task automatic test_latency();
    int la[2] = '{100, -100};
    int le[2] = '{141, -141};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, la[k], 1'b0);
      tick();
      drive(1'b0, 0, 1'b0);
      n_total++;
      if (out_valid0 !== 1'b0) $display("FAIL lat_edge1[%0d]: got %b want 0", k, out_valid0);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid0 !== 1'b0) $display("FAIL lat_edge2[%0d]: got %b want 0", k, out_valid0);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid0 !== 1'b1 || out_p0 !== 9'(le[k])) begin
        $display("FAIL lat_edge3[%0d]: got v=%b p=%h want v=1 p=%h", k, out_valid0, out_p0,
                 9'(le[k]));
      end else n_pass++;
    end
    tick();
  endtask

  task automatic test_arith();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ar_a[i], ar_s[i][0]);
      tick();
      drive(1'b0, 0, 1'b0);
      tick();
      tick();
      n_total++;
      if (out_valid0 !== 1'b1 || out_p0 !== 9'(ar_e0[i])) begin
        $display("FAIL arith_trunc[%0d]: got v=%b p=%h want v=1 p=%h", i, out_valid0, out_p0,
                 9'(ar_e0[i]));
      end else n_pass++;
      n_total++;
      if (out_valid1 !== 1'b1 || out_p1 !== 9'(ar_e1[i])) begin
        $display("FAIL arith_round[%0d]: got v=%b p=%h want v=1 p=%h", i, out_valid1, out_p1,
                 9'(ar_e1[i]));
      end else n_pass++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 12; j++) begin
      if (j < 10) drive(1'b1, st_a[j], 1'(j % 2));
      else drive(1'b0, 0, 1'b0);
      #1;
      n_total++;
      if (in_ready0 !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", j, in_ready0);
      else n_pass++;
      tick();
      if (j >= 2) begin
        n_total++;
        if (out_valid0 !== 1'b1 || out_p0 !== 9'(st_e0[j-2]) || out_p1 !== 9'(st_e1[j-2])) begin
          $display("FAIL stream[%0d]: got v=%b p=%h/%h want v=1 p=%h/%h", j - 2, out_valid0,
                   out_p0, out_p1, 9'(st_e0[j-2]), 9'(st_e1[j-2]));
        end else n_pass++;
      end
    end
    tick();
    n_total++;
    if (out_valid0 !== 1'b0) $display("FAIL stream_drain: got %b want 0", out_valid0);
    else n_pass++;
  endtask

  task automatic test_stall();
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, sl_a[j], sl_s[j][0]);
      tick();
    end
    drive(1'b0, 0, 1'b0);
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
        $display("FAIL stall_ready[%0d]: got %b/%b want 0/0", c, in_ready0, in_ready1);
      end else n_pass++;
      n_total++;
      if (out_valid0 !== 1'b1 || out_p0 !== 9'(sl_e0[0]) || out_p1 !== 9'(sl_e1[0])) begin
        $display("FAIL stall_hold[%0d]: got v=%b p=%h/%h want v=1 p=%h/%h", c, out_valid0,
                 out_p0, out_p1, 9'(sl_e0[0]), 9'(sl_e1[0]));
      end else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    for (int j = 1; j < 3; j++) begin
      tick();
      n_total++;
      if (out_valid0 !== 1'b1 || out_p0 !== 9'(sl_e0[j]) || out_p1 !== 9'(sl_e1[j])) begin
        $display("FAIL stall_release[%0d]: got v=%b p=%h/%h want v=1 p=%h/%h", j, out_valid0,
                 out_p0, out_p1, 9'(sl_e0[j]), 9'(sl_e1[j]));
      end else n_pass++;
    end
    tick();
    n_total++;
    if (out_valid0 !== 1'b0) $display("FAIL stall_drain: got %b want 0", out_valid0);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, sl_a[j], sl_s[j][0]);
      tick();
    end
    drive(1'b0, 0, 1'b0);
    rstn = 1'b0;
    #1;
    n_total++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || out_p0 !== 9'd0) begin
      $display("FAIL async_reset: got v=%b/%b p=%h want v=0/0 p=000", out_valid0, out_valid1,
               out_p0);
    end else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
        $display("FAIL reset_flush[%0d]: got %b/%b want 0/0", c, out_valid0, out_valid1);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
